// File: rtl/vend_controller.sv
// Vending sequencer: product selection, keystroke-counter control, coin credit,
// and dispense/change handshakes toward the mechanism drivers.
module vend_controller #(
   parameter int PRICE0  = 3,
   parameter int PRICE1  = 5,
   parameter int PRICE2  = 8,
   parameter int PRICE3  = 12,
   parameter int TIMEOUT = 1000
) (
   input  logic       vend_clk,
   input  logic       vend_reset,
   input  logic       sel_valid,
   input  logic [1:0] sel_id,
   input  logic       confirm,
   input  logic       cancel,
   input  logic       coin_valid,
   input  logic [1:0] coin_code,
   input  logic [3:0] cnt_count,
   input  logic       cnt_overflow,
   output logic       cnt_enable,
   output logic       cnt_reset_n,
   output logic       coin_reject,
   output logic       qty_full,
   output logic       dispense_valid,
   output logic [1:0] dispense_id,
   output logic [2:0] dispense_qty,
   input  logic       dispense_ack,
   output logic       change_valid,
   output logic [9:0] change_amount,
   input  logic       change_ack,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECT   = 3'd1,
      PAY      = 3'd2,
      DISPENSE = 3'd3,
      CHANGE   = 3'd4
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t         st;
   logic [1:0]     item;
   logic [2:0]     qty;
   logic [9:0]     total;
   logic [9:0]     credit;
   logic [TW-1:0]  timer;

   logic           coin_ok;
   logic [9:0]     coin_val;
   logic [10:0]    credit_sum;
   logic [9:0]     credit_next;
   logic [2:0]     qty_sel;
   logic [9:0]     unit_price;
   logic [9:0]     total_calc;
   logic           timeout_hit;

   assign state = st;

   assign coin_ok = coin_valid && (coin_code != 2'b00);

   always_comb begin
      coin_val = 10'd0;
      if (coin_valid) begin
         case (coin_code)
            2'b01:   coin_val = 10'd1;
            2'b10:   coin_val = 10'd5;
            2'b11:   coin_val = 10'd10;
            default: coin_val = 10'd0;
         endcase
      end
   end

   // Credit saturates rather than wrapping so a stuffed machine never loses money.
   assign credit_sum  = {1'b0, credit} + {1'b0, coin_val};
   assign credit_next = credit_sum[10] ? 10'd1023 : credit_sum[9:0];

   assign qty_sel = (cnt_count >= 4'd4) ? 3'd4 : cnt_count[2:0];

   always_comb begin
      unit_price = 10'(PRICE0);
      case (item)
         2'd1:    unit_price = 10'(PRICE1);
         2'd2:    unit_price = 10'(PRICE2);
         2'd3:    unit_price = 10'(PRICE3);
         default: unit_price = 10'(PRICE0);
      endcase
   end

   assign total_calc = unit_price * {7'd0, qty_sel};

   // A coin in the expiring cycle restarts the wait instead of refunding.
   assign timeout_hit = (timer == TW'(TIMEOUT - 1)) && !coin_ok;

   always_ff @(posedge vend_clk or negedge vend_reset) begin
      if (!vend_reset) begin
         st             <= IDLE;
         item           <= 2'd0;
         qty            <= 3'd0;
         total          <= 10'd0;
         credit         <= 10'd0;
         timer          <= '0;
         cnt_enable     <= 1'b0;
         cnt_reset_n    <= 1'b0;
         coin_reject    <= 1'b0;
         qty_full       <= 1'b0;
         dispense_valid <= 1'b0;
         dispense_id    <= 2'd0;
         dispense_qty   <= 3'd0;
         change_valid   <= 1'b0;
         change_amount  <= 10'd0;
      end else begin
         coin_reject <= 1'b0;
         case (st)
            IDLE: begin
               cnt_enable  <= 1'b0;
               cnt_reset_n <= 1'b1;
               qty_full    <= 1'b0;
               if (coin_ok) coin_reject <= 1'b1;
               if (sel_valid) begin
                  item        <= sel_id;
                  cnt_reset_n <= 1'b0;
                  cnt_enable  <= 1'b1;
                  st          <= SELECT;
               end
            end

            SELECT: begin
               cnt_enable  <= 1'b1;
               cnt_reset_n <= 1'b1;
               qty_full    <= cnt_overflow;
               if (coin_ok) coin_reject <= 1'b1;
               if (cancel) begin
                  cnt_enable <= 1'b0;
                  qty_full   <= 1'b0;
                  st         <= IDLE;
               end else if (sel_valid) begin
                  item        <= sel_id;
                  cnt_reset_n <= 1'b0;
               end else if (confirm && (cnt_count != 4'd0)) begin
                  qty        <= qty_sel;
                  total      <= total_calc;
                  credit     <= 10'd0;
                  timer      <= '0;
                  cnt_enable <= 1'b0;
                  st         <= PAY;
               end
            end

            PAY: begin
               credit <= credit_next;
               if (credit >= total) begin
                  dispense_valid <= 1'b1;
                  dispense_id    <= item;
                  dispense_qty   <= qty;
                  st             <= DISPENSE;
               end else if (cancel || timeout_hit) begin
                  timer <= '0;
                  if (credit_next == 10'd0) begin
                     total    <= 10'd0;
                     qty_full <= 1'b0;
                     st       <= IDLE;
                  end else begin
                     change_valid  <= 1'b1;
                     change_amount <= credit_next;
                     st            <= CHANGE;
                  end
               end else begin
                  timer <= coin_ok ? '0 : timer + 1'b1;
               end
            end

            DISPENSE: begin
               if (coin_ok) coin_reject <= 1'b1;
               if (dispense_ack) begin
                  dispense_valid <= 1'b0;
                  dispense_id    <= 2'd0;
                  dispense_qty   <= 3'd0;
                  if (credit > total) begin
                     change_valid  <= 1'b1;
                     change_amount <= credit - total;
                     st            <= CHANGE;
                  end else begin
                     credit   <= 10'd0;
                     total    <= 10'd0;
                     qty_full <= 1'b0;
                     st       <= IDLE;
                  end
               end
            end

            CHANGE: begin
               if (coin_ok) coin_reject <= 1'b1;
               if (change_ack) begin
                  change_valid  <= 1'b0;
                  change_amount <= 10'd0;
                  credit        <= 10'd0;
                  total         <= 10'd0;
                  qty_full      <= 1'b0;
                  st            <= IDLE;
               end
            end

            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level price model.
module tb_vend_controller;

   logic       vend_clk = 1'b0;
   logic       vend_reset;
   logic       sel_valid, confirm, cancel, coin_valid, cnt_overflow;
   logic [1:0] sel_id, coin_code;
   logic [3:0] cnt_count;
   logic       dispense_ack, change_ack;
   logic       cnt_enable, cnt_reset_n, coin_reject, qty_full;
   logic       dispense_valid, change_valid;
   logic [1:0] dispense_id;
   logic [2:0] dispense_qty;
   logic [9:0] change_amount;
   logic [2:0] state;

   int ncheck = 0;
   int nfail  = 0;

   vend_controller dut (
      .vend_clk(vend_clk), .vend_reset(vend_reset),
      .sel_valid(sel_valid), .sel_id(sel_id), .confirm(confirm), .cancel(cancel),
      .coin_valid(coin_valid), .coin_code(coin_code),
      .cnt_count(cnt_count), .cnt_overflow(cnt_overflow),
      .cnt_enable(cnt_enable), .cnt_reset_n(cnt_reset_n),
      .coin_reject(coin_reject), .qty_full(qty_full),
      .dispense_valid(dispense_valid), .dispense_id(dispense_id),
      .dispense_qty(dispense_qty), .dispense_ack(dispense_ack),
      .change_valid(change_valid), .change_amount(change_amount),
      .change_ack(change_ack), .state(state)
   );

   always #5 vend_clk = ~vend_clk;

   typedef struct {
      int sv, id, cf, cn, cv, cc, cnt, ovf, da, ca;
      int st, rej, cen, crn, qf, dv, did, dq, chv, camt;
   } vec_t;

   vec_t vecs[35];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncheck++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge vend_clk);
      #1;
   endtask

   task automatic clr_in();
      sel_valid = 0; confirm = 0; cancel = 0; coin_valid = 0; coin_code = 0;
      dispense_ack = 0; change_ack = 0;
   endtask

   function automatic int coin_units(input int code);
      case (code)
         1: return 1;
         2: return 5;
         3: return 10;
         default: return 0;
      endcase
   endfunction

   function automatic int price(input int id);
      case (id)
         0: return 3;
         1: return 5;
         2: return 8;
         default: return 12;
      endcase
   endfunction

   // Select item, load counter value, confirm: leaves the DUT in PAY.
   task automatic start_pay(input int id, input int q);
      sel_valid = 1; sel_id = 2'(id); tick(); clr_in();
      cnt_count = 4'(q); cnt_overflow = (q >= 4); tick();
      confirm = 1; tick(); clr_in();
   endtask

   task automatic coin(input int code);
      coin_valid = 1; coin_code = 2'(code); tick(); clr_in();
   endtask

   task automatic random_txn(input int n);
      int id, q, qty, tot, sum, code, w, cancel_after, ncoins;
      bit do_cancel;
      string p;
      p = $sformatf("rnd%0d", n);
      id = $urandom_range(0, 3);
      q = $urandom_range(1, 6);
      qty = (q > 4) ? 4 : q;
      tot = price(id) * qty;
      sum = 0;
      ncoins = 0;
      do_cancel = ($urandom_range(0, 3) == 0);
      cancel_after = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) begin
         coin($urandom_range(1, 3));
         chk({p, ".idle_reject"}, 32'(coin_reject), 1);
      end
      sel_valid = 1; sel_id = 2'(id); tick(); clr_in();
      chk({p, ".select"}, 32'(state), 1);
      chk({p, ".cnt_clear"}, 32'(cnt_reset_n), 0);
      cnt_count = 4'(q); cnt_overflow = (q >= 4); tick();
      chk({p, ".qty_full"}, 32'(qty_full), (q >= 4) ? 1 : 0);
      confirm = 1; tick(); clr_in();
      chk({p, ".pay"}, 32'(state), 2);
      while (sum < tot && !(do_cancel && ncoins == cancel_after)) begin
         code = $urandom_range(0, 3);
         sum += coin_units(code);
         coin(code);
         ncoins++;
         chk({p, ".still_pay"}, 32'(state), 2);
      end
      if (sum >= tot) begin
         tick();
         chk({p, ".dispense"}, 32'(state), 3);
         chk({p, ".disp_id"}, 32'(dispense_id), id);
         chk({p, ".disp_qty"}, 32'(dispense_qty), qty);
         w = $urandom_range(0, 3);
         repeat (w) tick();
         chk({p, ".disp_hold"}, 32'(dispense_valid), 1);
         dispense_ack = 1; tick(); clr_in();
         chk({p, ".disp_drop"}, 32'(dispense_valid), 0);
         sum = sum - tot;
      end else begin
         cancel = 1;
         if ($urandom_range(0, 1) == 1) begin
            code = $urandom_range(1, 3);
            coin_valid = 1; coin_code = 2'(code);
            sum += coin_units(code);
         end
         tick(); clr_in();
         chk({p, ".no_disp"}, 32'(dispense_valid), 0);
      end
      if (sum > 0) begin
         chk({p, ".change"}, 32'(state), 4);
         chk({p, ".change_amt"}, 32'(change_amount), sum);
         repeat ($urandom_range(0, 2)) tick();
         chk({p, ".change_hold"}, 32'(change_valid), 1);
         change_ack = 1; tick(); clr_in();
      end else begin
         chk({p, ".no_change"}, 32'(change_valid), 0);
      end
      chk({p, ".idle"}, 32'(state), 0);
   endtask

   initial begin
      // Test plans 1, 2, 5 as cycle vectors:
      // sv id cf cn cv cc cnt ovf da ca | st rej cen crn qf dv did dq chv camt
      vecs[0]  = '{1,1,0,0,0,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0};
      vecs[1]  = '{0,0,0,0,0,0,1,0,0,0, 1,0,1,1,0,0,0,0,0,0};
      vecs[2]  = '{0,0,0,0,0,0,2,0,0,0, 1,0,1,1,0,0,0,0,0,0};
      vecs[3]  = '{0,0,1,0,0,0,3,0,0,0, 2,0,0,1,0,0,0,0,0,0};
      vecs[4]  = '{0,0,0,0,1,3,0,0,0,0, 2,0,0,1,0,0,0,0,0,0};
      vecs[5]  = '{0,0,0,0,1,2,0,0,0,0, 2,0,0,1,0,0,0,0,0,0};
      vecs[6]  = '{0,0,0,0,0,0,0,0,0,0, 3,0,0,1,0,1,1,3,0,0};
      vecs[7]  = '{0,0,0,0,0,0,0,0,0,0, 3,0,0,1,0,1,1,3,0,0};
      vecs[8]  = '{0,0,0,0,0,0,0,0,1,0, 0,0,0,1,0,0,0,0,0,0};
      vecs[9]  = '{1,3,0,0,0,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0};
      vecs[10] = '{0,0,0,0,0,0,4,1,0,0, 1,0,1,1,1,0,0,0,0,0};
      vecs[11] = '{0,0,1,0,0,0,4,1,0,0, 2,0,0,1,1,0,0,0,0,0};
      vecs[12] = '{0,0,0,0,1,3,0,0,0,0, 2,0,0,1,1,0,0,0,0,0};
      vecs[13] = '{0,0,0,0,1,3,0,0,0,0, 2,0,0,1,1,0,0,0,0,0};
      vecs[14] = '{0,0,0,0,1,3,0,0,0,0, 2,0,0,1,1,0,0,0,0,0};
      vecs[15] = '{0,0,0,0,1,3,0,0,0,0, 2,0,0,1,1,0,0,0,0,0};
      vecs[16] = '{0,0,0,0,1,3,0,0,0,0, 2,0,0,1,1,0,0,0,0,0};
      vecs[17] = '{0,0,0,0,0,0,0,0,0,0, 3,0,0,1,1,1,3,4,0,0};
      vecs[18] = '{0,0,0,0,0,0,0,0,1,0, 4,0,0,1,1,0,0,0,1,2};
      vecs[19] = '{0,0,0,0,0,0,0,0,0,0, 4,0,0,1,1,0,0,0,1,2};
      vecs[20] = '{0,0,0,0,0,0,0,0,0,1, 0,0,0,1,0,0,0,0,0,0};
      vecs[21] = '{0,0,0,0,1,1,0,0,0,0, 0,1,0,1,0,0,0,0,0,0};
      vecs[22] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0,0,0};
      vecs[23] = '{1,0,0,0,0,0,0,0,0,0, 1,0,1,0,0,0,0,0,0,0};
      vecs[24] = '{0,0,0,0,1,2,0,0,0,0, 1,1,1,1,0,0,0,0,0,0};
      vecs[25] = '{0,0,1,0,0,0,0,0,0,0, 1,0,1,1,0,0,0,0,0,0};
      vecs[26] = '{0,0,1,0,0,0,2,0,0,0, 2,0,0,1,0,0,0,0,0,0};
      vecs[27] = '{0,0,0,0,1,3,0,0,0,0, 2,0,0,1,0,0,0,0,0,0};
      vecs[28] = '{0,0,0,0,0,0,0,0,0,0, 3,0,0,1,0,1,0,2,0,0};
      vecs[29] = '{0,0,0,0,1,1,0,0,0,0, 3,1,0,1,0,1,0,2,0,0};
      vecs[30] = '{0,0,0,1,0,0,0,0,0,0, 3,0,0,1,0,1,0,2,0,0};
      vecs[31] = '{0,0,0,0,0,0,0,0,1,0, 4,0,0,1,0,0,0,0,1,4};
      vecs[32] = '{0,0,0,0,0,0,0,0,0,1, 0,0,0,1,0,0,0,0,0,0};
      vecs[33] = '{0,0,0,0,0,0,0,0,1,1, 0,0,0,1,0,0,0,0,0,0};
      vecs[34] = '{0,0,0,0,1,0,0,0,0,0, 0,0,0,1,0,0,0,0,0,0};

      clr_in();
      sel_id = 0; cnt_count = 0; cnt_overflow = 0;
      vend_reset = 0;
      #3;
      chk("rst.state", 32'(state), 0);
      chk("rst.cnt_reset_n", 32'(cnt_reset_n), 0);
      chk("rst.outputs", {coin_reject, cnt_enable, qty_full, dispense_valid, change_valid}, 0);
      chk("rst.amounts", {dispense_id, dispense_qty, change_amount}, 0);
      repeat (2) @(posedge vend_clk);
      @(negedge vend_clk) vend_reset = 1;
      tick();
      chk("post_rst.state", 32'(state), 0);
      chk("post_rst.cnt_reset_n", 32'(cnt_reset_n), 1);

      for (int i = 0; i < 35; i++) begin
         sel_valid    = vecs[i].sv[0];
         sel_id       = vecs[i].id[1:0];
         confirm      = vecs[i].cf[0];
         cancel       = vecs[i].cn[0];
         coin_valid   = vecs[i].cv[0];
         coin_code    = vecs[i].cc[1:0];
         cnt_count    = vecs[i].cnt[3:0];
         cnt_overflow = vecs[i].ovf[0];
         dispense_ack = vecs[i].da[0];
         change_ack   = vecs[i].ca[0];
         tick();
         chk($sformatf("vec%0d.state", i), 32'(state), vecs[i].st);
         chk($sformatf("vec%0d.coin_reject", i), 32'(coin_reject), vecs[i].rej);
         chk($sformatf("vec%0d.cnt_enable", i), 32'(cnt_enable), vecs[i].cen);
         chk($sformatf("vec%0d.cnt_reset_n", i), 32'(cnt_reset_n), vecs[i].crn);
         chk($sformatf("vec%0d.qty_full", i), 32'(qty_full), vecs[i].qf);
         chk($sformatf("vec%0d.dispense_valid", i), 32'(dispense_valid), vecs[i].dv);
         chk($sformatf("vec%0d.dispense_id", i), 32'(dispense_id), vecs[i].did);
         chk($sformatf("vec%0d.dispense_qty", i), 32'(dispense_qty), vecs[i].dq);
         chk($sformatf("vec%0d.change_valid", i), 32'(change_valid), vecs[i].chv);
         chk($sformatf("vec%0d.change_amount", i), 32'(change_amount), vecs[i].camt);
      end
      clr_in();
      cnt_count = 0; cnt_overflow = 0;

      // Cancel together with a coin: the coin joins the refund.
      start_pay(0, 2);
      coin(2);
      chk("cancel_coin.pay", 32'(state), 2);
      cancel = 1; coin_valid = 1; coin_code = 2'b01; tick(); clr_in();
      chk("cancel_coin.state", 32'(state), 4);
      chk("cancel_coin.amount", 32'(change_amount), 6);
      chk("cancel_coin.no_disp", 32'(dispense_valid), 0);
      change_ack = 1; tick(); clr_in();
      chk("cancel_coin.idle", 32'(state), 0);

      // Timeout with credit 1: refund on the 1000th coin-free cycle.
      start_pay(0, 1);
      coin(1);
      repeat (999) tick();
      chk("timeout.before", 32'(state), 2);
      tick();
      chk("timeout.state", 32'(state), 4);
      chk("timeout.amount", 32'(change_amount), 1);
      change_ack = 1; tick(); clr_in();
      chk("timeout.idle", 32'(state), 0);

      // Timeout with no credit goes straight home.
      start_pay(2, 1);
      repeat (999) tick();
      chk("timeout0.before", 32'(state), 2);
      tick();
      chk("timeout0.state", 32'(state), 0);
      chk("timeout0.no_change", 32'(change_valid), 0);

      // Asynchronous reset mid-dispense with credit 20.
      start_pay(0, 2);
      coin(3);
      coin(3);
      tick();
      chk("arst.dispense", 32'(state), 3);
      #2 vend_reset = 0;
      #1;
      chk("arst.state", 32'(state), 0);
      chk("arst.cnt_reset_n", 32'(cnt_reset_n), 0);
      chk("arst.outputs", {coin_reject, cnt_enable, qty_full, dispense_valid, change_valid}, 0);
      chk("arst.amounts", {dispense_id, dispense_qty, change_amount}, 0);
      @(negedge vend_clk) vend_reset = 1;
      tick();
      chk("arst.rel_state", 32'(state), 0);
      chk("arst.rel_cnt_reset_n", 32'(cnt_reset_n), 1);
      start_pay(0, 1);
      tick(); tick();
      chk("arst.credit_cleared", 32'(state), 2);
      cancel = 1; tick(); clr_in();
      chk("arst.no_refund", 32'(change_valid), 0);
      chk("arst.idle", 32'(state), 0);

      for (int n = 0; n < 40; n++) random_txn(n);

      $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
      $finish;
   end

endmodule
